// File: rtl/riscv_v_instr_queue_pkg.sv
// Shared scalar types and the vector instruction-queue entry layout.
// riscv_pkg is shared with scalar bubble insertion; riscv_v_pkg holds queue-specific items.
package riscv_pkg;
   localparam int XLEN = 32;
   typedef logic [31:0]     riscv_instruction_t;
   typedef logic [XLEN-1:0] riscv_data_t;
   localparam riscv_instruction_t RISCV_NOP = 32'h0000_0013;
endpackage

package riscv_v_pkg;
   import riscv_pkg::*;
   localparam int RISCV_V_IQ_DEPTH = 4;
   typedef struct packed {
      riscv_instruction_t instruction;
      riscv_data_t        rs1_data;
   } riscv_v_iq_entry_t;
endpackage

// File: rtl/riscv_v_instr_queue_if.sv
// Scalar-issue push side and vector-decode head side of the instruction queue.
interface riscv_v_instr_queue_if #(parameter int DEPTH = 4);
   import riscv_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;

   logic               clear_pipe;
   logic               instr_valid_if;
   riscv_instruction_t instruction_if;
   riscv_data_t        int_rf_rd_data_if;
   logic               instr_ready_if;
   logic               riscv_v_stall;
   riscv_instruction_t instruction_id;
   riscv_data_t        int_rf_rd_data_id;
   logic               instr_valid_id;
   logic [CW-1:0]      occupancy;
   logic               overflow_err;

   modport slave (
      input  clear_pipe, instr_valid_if, instruction_if, int_rf_rd_data_if, riscv_v_stall,
      output instr_ready_if, instruction_id, int_rf_rd_data_id, instr_valid_id,
             occupancy, overflow_err
   );

   modport master (
      output clear_pipe, instr_valid_if, instruction_if, int_rf_rd_data_if, riscv_v_stall,
      input  instr_ready_if, instruction_id, int_rf_rd_data_id, instr_valid_id,
             occupancy, overflow_err
   );
endinterface

// File: rtl/riscv_v_iq_fifo.sv
// Generic synchronous FIFO with count/full/empty and synchronous flush; read data is a mux on rptr.
// Pushes when full and pops when empty are ignored; storage itself is never reset.
module riscv_v_iq_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    cnt;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign count   = cnt;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/riscv_v_instr_queue.sv
// Decouples scalar issue from vector decode; ready comes only from registered fill state,
// so a decode stall never reaches scalar issue combinationally. Empty head reads as a NOP.
module riscv_v_instr_queue
   import riscv_pkg::*;
   import riscv_v_pkg::*;
#(
   parameter int DEPTH = RISCV_V_IQ_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   riscv_v_instr_queue_if.slave  q
);
   localparam int CW = $clog2(DEPTH) + 1;

   riscv_v_iq_entry_t wr_entry;
   riscv_v_iq_entry_t rd_entry;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              overflow_q;

   assign wr_entry.instruction = q.instruction_if;
   assign wr_entry.rs1_data    = q.int_rf_rd_data_if;

   assign push = q.instr_valid_if & ~full;
   assign pop  = ~empty & ~q.riscv_v_stall;

   riscv_v_iq_fifo #(
      .WIDTH ($bits(riscv_v_iq_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (q.clear_pipe),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // A dropped push is sticky until reset; a flush neither sets nor clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_q <= 1'b0;
      else if (q.instr_valid_if && full && !q.clear_pipe)
         overflow_q <= 1'b1;
   end

   assign q.instr_ready_if    = ~full;
   assign q.occupancy         = count;
   assign q.overflow_err      = overflow_q;
   assign q.instr_valid_id    = ~empty;
   assign q.instruction_id    = empty ? RISCV_NOP : rd_entry.instruction;
   assign q.int_rf_rd_data_id = empty ? '0 : rd_entry.rs1_data;
endmodule
